conv0_column_sequencer: RTL and testbench
=========================================

// Module: conv0_column_sequencer
// PURPOSE
//  Controller and consumer on the far side of the layer-0 convolution start/done interface.
//  Issues one conv_start per output column and waits for the AND-ed kernel done.
//  Captures all NUM_KERNELS result columns, then drains them as a valid/ready word stream to pooling.
//  Pre-issues the next column's start at capture, so convolution overlaps with the drain.
// PARAMETERS
//  DATA_WIDTH   16  bits per feature-map word
//  NUM_KERNELS  4   kernels computed in parallel by the conv layer
//  COL_LEN      24  words per kernel column (rows of output feature map)
//  NUM_COLS     24  columns per frame (output feature-map width)
// PORTS
//  clk          in   1                        system clock, rising edge
//  rst          in   1                        asynchronous, active-low reset
//  frame_start  in   1                        pulse: begin a frame; ignored while busy
//  conv_start   out  1                        one-cycle pulse to conv layer
//  conv_done    in   1                        level, high when all kernels finished the column
//  col_in       in   DATA_WIDTH x [0:NUM_KERNELS*COL_LEN-1]   kernel k at [k*COL_LEN +: COL_LEN]
//  m_valid      out  1                        stream word valid
//  m_ready      in   1                        downstream accepts word
//  m_data       out  DATA_WIDTH               feature word
//  m_kernel     out  $clog2(NUM_KERNELS)      kernel index of m_data
//  m_row        out  $clog2(COL_LEN)          row index of m_data
//  m_col        out  $clog2(NUM_COLS)         column index of m_data
//  m_last       out  1                        last word of frame (k,row,col all max)
//  busy         out  1                        high from accepted frame_start to frame_done
//  frame_done   out  1                        one-cycle pulse after last word accepted
// BEHAVIOUR
//  Reset (rst=0, async): all outputs 0, FSM IDLE, counters 0, pending=0, capture buffer cleared.
//  FSM: IDLE -> ISSUE -> WAIT -> CAPTURE -> DRAIN -> (WAIT | CAPTURE | FIN) -> IDLE.
//  IDLE: frame_start=1 -> ISSUE; issue_col=0, drain_col=0; busy=1 from next cycle.
//  ISSUE: conv_start=1 for exactly one cycle -> WAIT.
//  WAIT: done event -> CAPTURE. Done event = conv_done rising edge (registered previous value).
//  CAPTURE (1 cycle): copy all col_in words into buffer, m_col<=issue_col.
//   If issue_col<NUM_COLS-1: pulse conv_start the same cycle and increment issue_col.
//   Go to DRAIN.
//  DRAIN: stream order kernel-major, then row: (k0,r0),(k0,r1)..(k0,rCOL_LEN-1),(k1,r0)...
//   m_valid held high until m_valid&&m_ready; m_data/m_kernel/m_row/m_col/m_last stable while stalled.
//   Back-to-back: one word per cycle when m_ready=1; a column takes NUM_KERNELS*COL_LEN beats.
//   Done event during DRAIN sets pending=1; the event is not lost.
//  End of column drain (last beat accepted):
//   Last column -> FIN.
//   pending=1, or done event in the same cycle -> CAPTURE; clear pending.
//   Otherwise -> WAIT. m_valid drops to 0 for at least one cycle between columns.
//  FIN: frame_done=1 one cycle, busy=0 next cycle, -> IDLE.
//  conv_start is never asserted in IDLE/FIN. Total starts per frame = NUM_COLS exactly.
//  frame_start while busy: ignored, no effect on counters.
//  Done event in IDLE/ISSUE/CAPTURE/FIN: ignored; no pending set.
//  m_last=1 only on (k=NUM_KERNELS-1, row=COL_LEN-1, col=NUM_COLS-1).
//  Reset mid-frame: immediate abort to reset values; no frame_done; next frame restarts at col 0.
//  No arithmetic on data: m_data is a bit-exact copy of the captured col_in word.
// TESTING
//  1 Reset mid-drain: rst=0 at beat 10 of column 3.
//    -> all outputs 0 immediately.
//    -> a new frame_start yields conv_start, then m_col=0.
//  2 Nominal frame with m_ready=1 and conv_done 5 cycles after each start; col_in word = {k,row,col}.
//    -> 24 conv_start pulses.
//    -> 2304 beats in kernel/row/col order, each m_data matching its index tag.
//    -> m_last on beat 2304, frame_done the next cycle.
//  3 Backpressure: m_ready toggles 1,0,0,1 pseudo-randomly.
//    -> m_data/indices stable whenever m_valid && !m_ready.
//    -> no word dropped or duplicated.
//  4 Early done: conv_done rises 2 cycles after a CAPTURE, while the drain takes 96 cycles.
//    -> pending set.
//    -> CAPTURE occurs the cycle after the last beat.
//    -> next column data correct, with no extra conv_start.
//  5 frame_start pulsed while busy at column 7 -> ignored, exactly 24 starts, single frame_done.
//  6 Params NUM_KERNELS=1, COL_LEN=2, NUM_COLS=1 -> one conv_start, 2 beats, m_last on beat 2.

Source files
------------

// File: rtl/conv0_column_sequencer.sv
// Layer-0 convolution column sequencer: issues one conv_start per output column, captures
// the finished kernel columns and drains them to pooling as a valid/ready word stream.
module conv0_column_sequencer #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_KERNELS = 4,
    parameter int COL_LEN     = 24,
    parameter int NUM_COLS    = 24,
    localparam int KW = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1,
    localparam int RW = (COL_LEN > 1) ? $clog2(COL_LEN) : 1,
    localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    output logic                  conv_start,
    input  logic                  conv_done,
    input  logic [DATA_WIDTH-1:0] col_in [0:NUM_KERNELS*COL_LEN-1],
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [KW-1:0]         m_kernel,
    output logic [RW-1:0]         m_row,
    output logic [CW-1:0]         m_col,
    output logic                  m_last,
    output logic                  busy,
    output logic                  frame_done,
    output logic [2:0]            state_dbg
);

    localparam int BUF_WORDS = NUM_KERNELS * COL_LEN;
    localparam int IW = (BUF_WORDS > 1) ? $clog2(BUF_WORDS) : 1;
    localparam logic [KW-1:0] K_MAX = KW'(NUM_KERNELS - 1);
    localparam logic [RW-1:0] R_MAX = RW'(COL_LEN - 1);
    localparam logic [CW-1:0] C_MAX = CW'(NUM_COLS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_DRAIN   = 3'd4,
        S_FIN     = 3'd5
    } state_t;

    state_t                state;
    logic                  conv_done_q;
    logic                  pending;
    logic [CW-1:0]         issue_col;
    logic [IW-1:0]         rd_idx;
    logic [DATA_WIDTH-1:0] cap_buf [0:BUF_WORDS-1];

    logic done_evt;
    logic more_cols;
    logic col_end;

    // Stream handshake: a word moves on a cycle where m_valid && m_ready at the rising edge;
    // while m_valid is high and m_ready low every m_* output holds its value.
    assign done_evt  = conv_done & ~conv_done_q;
    assign more_cols = (issue_col < C_MAX);
    assign col_end   = (m_kernel == K_MAX) && (m_row == R_MAX);
    assign m_data    = cap_buf[rd_idx];
    assign m_last    = m_valid && col_end && (m_col == C_MAX);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            conv_done_q <= 1'b0;
            conv_start  <= 1'b0;
            pending     <= 1'b0;
            issue_col   <= '0;
            rd_idx      <= '0;
            m_valid     <= 1'b0;
            m_kernel    <= '0;
            m_row       <= '0;
            m_col       <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            for (int i = 0; i < BUF_WORDS; i++) cap_buf[i] <= '0;
        end else begin
            conv_done_q <= conv_done;
            conv_start  <= 1'b0;
            frame_done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        state      <= S_ISSUE;
                        conv_start <= 1'b1;
                        busy       <= 1'b1;
                        issue_col  <= '0;
                        m_col      <= '0;
                        pending    <= 1'b0;
                    end
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    // conv_start rides on the CAPTURE cycle so the next column overlaps the drain
                    if (done_evt) begin
                        state      <= S_CAPTURE;
                        conv_start <= more_cols;
                    end
                end
                S_CAPTURE: begin
                    for (int i = 0; i < BUF_WORDS; i++) cap_buf[i] <= col_in[i];
                    m_col    <= issue_col;
                    if (more_cols) issue_col <= issue_col + 1'b1;
                    m_valid  <= 1'b1;
                    m_kernel <= '0;
                    m_row    <= '0;
                    rd_idx   <= '0;
                    state    <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (done_evt) pending <= 1'b1;
                    if (m_valid && m_ready) begin
                        if (col_end) begin
                            m_valid  <= 1'b0;
                            m_kernel <= '0;
                            m_row    <= '0;
                            rd_idx   <= '0;
                            if (m_col == C_MAX) begin
                                state      <= S_FIN;
                                frame_done <= 1'b1;
                            end else if (pending || done_evt) begin
                                state      <= S_CAPTURE;
                                pending    <= 1'b0;
                                conv_start <= more_cols;
                            end else begin
                                state <= S_WAIT;
                            end
                        end else begin
                            rd_idx <= rd_idx + 1'b1;
                            if (m_row == R_MAX) begin
                                m_row    <= '0;
                                m_kernel <= m_kernel + 1'b1;
                            end else begin
                                m_row <= m_row + 1'b1;
                            end
                        end
                    end
                end
                S_FIN: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv0_column_sequencer.sv
// Bench for conv0_column_sequencer: conv-layer responder, stream scoreboard and directed frames
// (reset abort, nominal, backpressure, early done, busy frame_start, minimal parameter set).
module tb_conv0_column_sequencer;

    localparam int NK = 4;
    localparam int CL = 24;
    localparam int NC = 24;
    localparam int BEATS_COL   = NK * CL;
    localparam int BEATS_FRAME = NK * CL * NC;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // main DUT signals
    logic        frame_start, conv_start, conv_done, m_valid, m_ready, m_last, busy, frame_done;
    logic [15:0] col_in [0:BEATS_COL-1];
    logic [15:0] m_data;
    logic [1:0]  m_kernel;
    logic [4:0]  m_row, m_col;
    logic [2:0]  state_dbg;

    // minimal-parameter DUT signals
    logic        frame_start6, conv_start6, conv_done6, m_valid6, m_ready6, m_last6, busy6, frame_done6;
    logic [15:0] col_in6 [0:1];
    logic [15:0] m_data6;
    logic        m_kernel6, m_row6, m_col6;
    logic [2:0]  state_dbg6;

    conv0_column_sequencer dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .conv_start(conv_start),
        .conv_done(conv_done), .col_in(col_in), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_kernel(m_kernel), .m_row(m_row), .m_col(m_col), .m_last(m_last),
        .busy(busy), .frame_done(frame_done), .state_dbg(state_dbg)
    );

    conv0_column_sequencer #(.DATA_WIDTH(16), .NUM_KERNELS(1), .COL_LEN(2), .NUM_COLS(1)) dut6 (
        .clk(clk), .rst(rst), .frame_start(frame_start6), .conv_start(conv_start6),
        .conv_done(conv_done6), .col_in(col_in6), .m_valid(m_valid6), .m_ready(m_ready6),
        .m_data(m_data6), .m_kernel(m_kernel6), .m_row(m_row6), .m_col(m_col6), .m_last(m_last6),
        .busy(busy6), .frame_done(frame_done6), .state_dbg(state_dbg6)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] tag(input int k, input int r, input int c);
        return {4'(k), 6'(r), 6'(c)};
    endfunction

    // scoreboard and responder state
    logic [15:0] exp_q[$];
    logic [15:0] mon_e;
    logic [3:0]  rdy_pat = 4'b1001;
    int  beats, cyc, starts, fd_cnt, last_beat, last_cyc, fd_cyc, gap_col, model_col, cd;
    int  done_delay;
    bit  ready_rand, expect_fast, chk_next, prev_stall;
    logic [15:0] prev_data;
    logic [1:0]  prev_k;
    logic [4:0]  prev_r, prev_c;
    logic        prev_last;

    // conv-layer responder, ready generator and stream monitor, all on the falling edge
    initial begin
        cyc = 0; cd = 0; model_col = 0; chk_next = 0; prev_stall = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                prev_stall = 0; chk_next = 0; cd = 0; conv_done = 1'b0;
            end else begin
                if (chk_next) begin
                    check_eq("col_gap_valid", 32'(m_valid), 0);
                    check_eq("col_gap_state", 32'(state_dbg), expect_fast ? 3 : 2);
                    if (expect_fast) check_eq("col_gap_start", 32'(conv_start), (gap_col + 1 < NC - 1) ? 1 : 0);
                    chk_next = 0;
                end
                if (prev_stall) begin
                    check_eq("stall_valid", 32'(m_valid), 1);
                    check_eq("stall_data", 32'(m_data), 32'(prev_data));
                    check_eq("stall_kernel", 32'(m_kernel), 32'(prev_k));
                    check_eq("stall_row", 32'(m_row), 32'(prev_r));
                    check_eq("stall_col", 32'(m_col), 32'(prev_c));
                    check_eq("stall_last", 32'(m_last), 32'(prev_last));
                end
                if (conv_start) begin
                    model_col = starts;
                    starts++;
                    conv_done = 1'b0;
                    cd = done_delay;
                end else if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        for (int k = 0; k < NK; k++)
                            for (int r = 0; r < CL; r++) col_in[k*CL + r] = tag(k, r, model_col);
                        conv_done = 1'b1;
                    end
                end
                if (frame_done) begin
                    fd_cnt++;
                    fd_cyc = cyc;
                end
                m_ready = ready_rand ? rdy_pat[$urandom_range(0, 3)] : 1'b1;
                if (m_valid && m_ready) begin
                    beats++;
                    if (exp_q.size() == 0) begin
                        check_eq("sb_extra_word", exp_q.size(), 1);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check_eq("sb_data", 32'(m_data), 32'(mon_e));
                        check_eq("sb_kernel", 32'(m_kernel), 32'(mon_e[15:12]));
                        check_eq("sb_row", 32'(m_row), 32'(mon_e[11:6]));
                        check_eq("sb_col", 32'(m_col), 32'(mon_e[5:0]));
                        check_eq("sb_last", 32'(m_last),
                                 (mon_e[15:12] == NK-1 && mon_e[11:6] == CL-1 && mon_e[5:0] == NC-1) ? 1 : 0);
                        if (mon_e[15:12] == NK-1 && mon_e[11:6] == CL-1 && mon_e[5:0] != NC-1) begin
                            chk_next = 1;
                            gap_col = int'(mon_e[5:0]);
                        end
                    end
                    if (m_last) begin
                        last_beat = beats;
                        last_cyc = cyc;
                    end
                end
                prev_stall = m_valid && !m_ready;
                prev_data = m_data; prev_k = m_kernel; prev_r = m_row; prev_c = m_col; prev_last = m_last;
            end
        end
    end

    task automatic check_reset_outputs(input string sfx);
        check_eq({"rst_conv_start", sfx}, 32'(conv_start), 0);
        check_eq({"rst_m_valid", sfx}, 32'(m_valid), 0);
        check_eq({"rst_m_data", sfx}, 32'(m_data), 0);
        check_eq({"rst_m_kernel", sfx}, 32'(m_kernel), 0);
        check_eq({"rst_m_row", sfx}, 32'(m_row), 0);
        check_eq({"rst_m_col", sfx}, 32'(m_col), 0);
        check_eq({"rst_m_last", sfx}, 32'(m_last), 0);
        check_eq({"rst_busy", sfx}, 32'(busy), 0);
        check_eq({"rst_frame_done", sfx}, 32'(frame_done), 0);
        check_eq({"rst_state", sfx}, 32'(state_dbg), 0);
    endtask

    // driver: one frame on the main DUT; inject_at pulses frame_start while busy, abort_at resets
    task automatic run_frame(input int delay, input bit rnd, input bit fast,
                             input int inject_at, input int abort_at);
        bit injected;
        injected = 0;
        done_delay = delay; ready_rand = rnd; expect_fast = fast;
        starts = 0; fd_cnt = 0; beats = 0; last_beat = 0; last_cyc = 0; fd_cyc = 0;
        for (int c = 0; c < NC; c++)
            for (int k = 0; k < NK; k++)
                for (int r = 0; r < CL; r++) exp_q.push_back(tag(k, r, c));
        @(negedge clk); frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
        check_eq("busy_on", 32'(busy), 1);
        for (int t = 0; t < 20 && starts == 0; t++) @(negedge clk);
        check_eq("first_start", starts, 1);
        for (int t = 0; t < 20000 && fd_cnt == 0; t++) begin
            @(negedge clk);
            frame_start = 1'b0;
            if (inject_at > 0 && !injected && beats >= inject_at) begin
                check_eq("inject_busy", 32'(busy), 1);
                frame_start = 1'b1;
                injected = 1;
            end
            if (abort_at > 0 && beats >= abort_at) begin
                #2 rst = 1'b0;
                #1 check_reset_outputs("_abort");
                exp_q.delete();
                repeat (2) @(negedge clk);
                rst = 1'b1;
                return;
            end
        end
        frame_start = 1'b0;
        check_eq("frame_done_seen", fd_cnt, 1);
        repeat (3) @(negedge clk);
        check_eq("starts_per_frame", starts, NC);
        check_eq("frame_done_count", fd_cnt, 1);
        check_eq("beats_per_frame", beats, BEATS_FRAME);
        check_eq("sb_leftover", exp_q.size(), 0);
        check_eq("last_beat_index", last_beat, BEATS_FRAME);
        check_eq("frame_done_latency", fd_cyc - last_cyc, 1);
        check_eq("busy_off", 32'(busy), 0);
        exp_q.delete();
    endtask

    // minimal configuration: one kernel, two rows, one column
    task automatic run_small_frame();
        int starts6, beats6, last6, fd6, cd6;
        starts6 = 0; beats6 = 0; last6 = 0; fd6 = 0; cd6 = 0;
        @(negedge clk); frame_start6 = 1'b1;
        @(negedge clk); frame_start6 = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (conv_start6) begin
                starts6++;
                conv_done6 = 1'b0;
                cd6 = 3;
            end else if (cd6 > 0) begin
                cd6--;
                if (cd6 == 0) begin
                    col_in6[0] = 16'hA5A0;
                    col_in6[1] = 16'hA5A1;
                    conv_done6 = 1'b1;
                end
            end
            if (m_valid6 && m_ready6) begin
                beats6++;
                check_eq("t6_data", 32'(m_data6), (beats6 == 1) ? 32'hA5A0 : 32'hA5A1);
                check_eq("t6_row", 32'(m_row6), beats6 - 1);
                if (m_last6) last6 = beats6;
            end
            if (frame_done6) fd6++;
            @(negedge clk);
        end
        check_eq("t6_starts", starts6, 1);
        check_eq("t6_beats", beats6, 2);
        check_eq("t6_last_beat", last6, 2);
        check_eq("t6_frame_done", fd6, 1);
        check_eq("t6_busy_off", 32'(busy6), 0);
    endtask

    initial begin
        rst = 1'b0;
        frame_start = 1'b0; conv_done = 1'b0; m_ready = 1'b1;
        frame_start6 = 1'b0; conv_done6 = 1'b0; m_ready6 = 1'b1;
        done_delay = 5; ready_rand = 0; expect_fast = 1;
        starts = 0; fd_cnt = 0; beats = 0;
        for (int i = 0; i < BEATS_COL; i++) col_in[i] = '0;
        col_in6[0] = '0; col_in6[1] = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("_init");
        check_eq("rst_m_valid6", 32'(m_valid6), 0);
        check_eq("rst_busy6", 32'(busy6), 0);
        check_eq("rst_conv_start6", 32'(conv_start6), 0);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);

        run_frame(5, 0, 1, 0, 3*BEATS_COL + 10);     // reset at beat 10 of column 3
        repeat (2) @(negedge clk);
        run_frame(5, 0, 1, 0, 0);                    // nominal, restarts at column 0
        run_frame(5, 1, 1, 0, 0);                    // backpressure
        run_frame(2, 0, 1, 7*BEATS_COL + 5, 0);      // early done + frame_start while busy
        run_frame(120, 0, 0, 0, 0);                  // late done: drain ends in WAIT
        run_small_frame();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
